// File: rtl/turbo_deframer_if.sv
// Triplet stream into the deframer and the per-triplet / per-block report out of it.
// The master side is the encoder output (or a bench); the slave side is the deframer.
interface turbo_deframer_if #(
    parameter int CNT_W = 14
);
    logic             look_now;
    logic             length_in;
    logic             xk;
    logic             zk;
    logic             zkp;
    logic             sys_bit;
    logic             par1_bit;
    logic             par2_bit;
    logic             bit_valid;
    logic [CNT_W-1:0] bit_idx;
    logic             sof;
    logic             eof;
    logic [11:0]      tail_bits;
    logic             block_done;
    logic             parity_err;
    logic             gap_err;
    logic [1:0]       state;

    modport master (
        output look_now, length_in, xk, zk, zkp,
        input  sys_bit, par1_bit, par2_bit, bit_valid, bit_idx, sof, eof,
        input  tail_bits, block_done, parity_err, gap_err, state
    );

    modport slave (
        input  look_now, length_in, xk, zk, zkp,
        output sys_bit, par1_bit, par2_bit, bit_valid, bit_idx, sof, eof,
        output tail_bits, block_done, parity_err, gap_err, state
    );
endinterface

// File: rtl/turbo_deframer.sv
// Splits the turbo encoder's serial triplet stream into K data triplets and 4 tail
// triplets per block, re-running the constituent RSC encoder to check parity-1.
//
// state | meaning
// IDLE  | waiting for the first triplet of a block
// DATA  | accepting data triplets 1..K-1
// TAIL  | accepting the 4 trellis-tail triplets
module turbo_deframer #(
    parameter int K_SHORT = 4,
    parameter int K_LONG  = 6,
    parameter int CNT_W   = 14
) (
    input logic             clk,
    input logic             rst,
    turbo_deframer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] K_S = CNT_W'(K_SHORT);
    localparam logic [CNT_W-1:0] K_L = CNT_W'(K_LONG);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [1:0]       tcnt_q, tcnt_d;
    logic [2:0]       s_q, s_d;
    logic             err_q, err_d;

    logic             sys_q, sys_d;
    logic             par1_q, par1_d;
    logic             par2_q, par2_d;
    logic             bit_valid_q, bit_valid_d;
    logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic [11:0]      tail_q, tail_d;
    logic             block_done_q, block_done_d;
    logic             parity_err_q, parity_err_d;
    logic             gap_err_q, gap_err_d;

    logic             take_data;
    logic [CNT_W-1:0] cur_idx;
    logic [CNT_W-1:0] cur_k;
    logic [2:0]       s_cur;
    logic             err_cur;
    logic             fb_a;
    logic             exp_z;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        idx_d        = idx_q;
        tcnt_d       = tcnt_q;
        s_d          = s_q;
        err_d        = err_q;
        sys_d        = sys_q;
        par1_d       = par1_q;
        par2_d       = par2_q;
        bit_valid_d  = 1'b0;
        bit_idx_d    = bit_idx_q;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        tail_d       = tail_q;
        block_done_d = 1'b0;
        parity_err_d = parity_err_q;
        gap_err_d    = 1'b0;

        take_data = 1'b0;
        cur_idx   = idx_q;
        cur_k     = k_q;
        s_cur     = s_q;
        err_cur   = err_q;
        fb_a      = 1'b0;
        exp_z     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.look_now) begin
                    take_data = 1'b1;
                    cur_idx   = '0;
                    cur_k     = bus.length_in ? K_L : K_S;
                    s_cur     = 3'b000;
                    err_cur   = 1'b0;
                end
            end
            DATA: begin
                if (bus.look_now) begin
                    take_data = 1'b1;
                end else begin
                    gap_err_d = 1'b1;
                    state_d   = IDLE;
                    idx_d     = '0;
                    tcnt_d    = 2'd0;
                end
            end
            TAIL: begin
                if (bus.look_now) begin
                    tail_d = {tail_q[8:0], bus.xk, bus.zk, bus.zkp};
                    if (tcnt_q == 2'd3) begin
                        block_done_d = 1'b1;
                        parity_err_d = err_q;
                        state_d      = IDLE;
                        tcnt_d       = 2'd0;
                        idx_d        = '0;
                    end else begin
                        tcnt_d = tcnt_q + 2'd1;
                    end
                end else begin
                    gap_err_d = 1'b1;
                    state_d   = IDLE;
                    idx_d     = '0;
                    tcnt_d    = 2'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Feedback a drives the shift register; parity-1 taps are a, D and D^3.
        if (take_data) begin
            fb_a        = bus.xk ^ s_cur[1] ^ s_cur[2];
            exp_z       = fb_a ^ s_cur[0] ^ s_cur[2];
            s_d         = {s_cur[1], s_cur[0], fb_a};
            err_d       = err_cur | (bus.zk ^ exp_z);
            k_d         = cur_k;
            sys_d       = bus.xk;
            par1_d      = bus.zk;
            par2_d      = bus.zkp;
            bit_valid_d = 1'b1;
            bit_idx_d   = cur_idx;
            sof_d       = (cur_idx == '0);
            eof_d       = (cur_idx == cur_k - ONE);
            if (cur_idx == cur_k - ONE) begin
                state_d = TAIL;
                tcnt_d  = 2'd0;
                idx_d   = '0;
            end else begin
                state_d = DATA;
                idx_d   = cur_idx + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            idx_q        <= '0;
            tcnt_q       <= 2'd0;
            s_q          <= 3'b000;
            err_q        <= 1'b0;
            sys_q        <= 1'b0;
            par1_q       <= 1'b0;
            par2_q       <= 1'b0;
            bit_valid_q  <= 1'b0;
            bit_idx_q    <= '0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            tail_q       <= 12'd0;
            block_done_q <= 1'b0;
            parity_err_q <= 1'b0;
            gap_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            idx_q        <= idx_d;
            tcnt_q       <= tcnt_d;
            s_q          <= s_d;
            err_q        <= err_d;
            sys_q        <= sys_d;
            par1_q       <= par1_d;
            par2_q       <= par2_d;
            bit_valid_q  <= bit_valid_d;
            bit_idx_q    <= bit_idx_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            tail_q       <= tail_d;
            block_done_q <= block_done_d;
            parity_err_q <= parity_err_d;
            gap_err_q    <= gap_err_d;
        end
    end

    assign bus.sys_bit    = sys_q;
    assign bus.par1_bit   = par1_q;
    assign bus.par2_bit   = par2_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.bit_idx    = bit_idx_q;
    assign bus.sof        = sof_q;
    assign bus.eof        = eof_q;
    assign bus.tail_bits  = tail_q;
    assign bus.block_done = block_done_q;
    assign bus.parity_err = parity_err_q;
    assign bus.gap_err    = gap_err_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_turbo_deframer.sv
// Scoreboard bench for turbo_deframer: the driver queues the expected output events with
// the cycle they must appear in, and a negedge monitor pops and compares them.
module tb_turbo_deframer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned cyc = 0;
    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] dq[$];
    logic [63:0] bq[$];
    logic [63:0] gq[$];
    logic [63:0] e;

    turbo_deframer_if #(.CNT_W(14)) bus ();

    turbo_deframer #(.K_SHORT(4), .K_LONG(6), .CNT_W(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.sys_bit, bus.par1_bit, bus.par2_bit, bus.bit_valid, bus.bit_idx,
                    bus.sof, bus.eof, bus.tail_bits, bus.block_done, bus.parity_err,
                    bus.gap_err, bus.state});
    endfunction

    // monitor: every output event must match the head of its queue, cycle included
    always @(negedge clk) begin
        if (bus.bit_valid) begin
            if (dq.size() == 0) check("unexpected_bit_valid", 64'(bus.bit_valid), 64'd0);
            else begin
                e = dq.pop_front();
                check("data", 64'({cyc, bus.sys_bit, bus.par1_bit, bus.par2_bit, bus.bit_idx,
                                   bus.sof, bus.eof}), e);
            end
        end
        if (bus.block_done) begin
            if (bq.size() == 0) check("unexpected_block_done", 64'(bus.block_done), 64'd0);
            else begin
                e = bq.pop_front();
                check("block_done", 64'({cyc, bus.tail_bits, bus.parity_err}), e);
            end
        end
        if (bus.gap_err) begin
            if (gq.size() == 0) check("unexpected_gap_err", 64'(bus.gap_err), 64'd0);
            else begin
                e = gq.pop_front();
                check("gap_err", 64'({cyc, bus.state, bus.parity_err}), e);
            end
        end
    end

    task automatic drv(input bit lk, input bit len, input bit x, input bit z, input bit zp);
        @(negedge clk);
        bus.look_now  = lk;
        bus.length_in = len;
        bus.xk        = x;
        bus.zk        = z;
        bus.zkp       = zp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0);
    endtask

    // perr: expected parity_err at block_done, or the held value when aborting.
    // abort_at: data index where look_now drops (-1 none); rst_tail: tail index hit by reset.
    task automatic send_block(input bit len, input int k, input logic [5:0] x,
                              input logic [5:0] z, input logic [5:0] zp,
                              input logic [11:0] tl, input bit perr,
                              input int abort_at, input int rst_tail);
        for (int i = 0; i < k; i++) begin
            if (i == abort_at) begin
                drv(0, 0, 0, 0, 0);
                gq.push_back(64'({cyc + 32'd1, 2'd0, perr}));
                return;
            end
            drv(1, len, x[i], z[i], zp[i]);
            dq.push_back(64'({cyc + 32'd1, x[i], z[i], zp[i], 14'(i), (i == 0), (i == k - 1)}));
        end
        for (int j = 0; j < 4; j++) begin
            drv(1, len, tl[11 - 3 * j], tl[10 - 3 * j], tl[9 - 3 * j]);
            if (j == rst_tail) begin
                check("state_in_tail", 64'(bus.state), 64'd2);
                #2 rst = 1'b0;
                #1 check("reset_mid_tail", all_outs(), 64'd0);
                return;
            end
        end
        bq.push_back(64'({cyc + 32'd1, tl, perr}));
    endtask

    localparam logic [5:0] PX  = 6'b001101;   // x = 1,0,1,1 (index 0 in bit 0)
    localparam logic [5:0] PZ  = 6'b001011;   // z = 1,1,0,1
    localparam logic [5:0] FZ  = 6'b001111;   // z[2] flipped
    localparam logic [5:0] PZP = 6'b001001;
    localparam logic [5:0] PZ6 = 6'b001011;   // x 1,0,1,1,0,0 keeps z 1,1,0,1,0,0
    localparam logic [5:0] ZP6 = 6'b101001;

    initial begin
        bus.look_now  = 1'b0;
        bus.length_in = 1'b0;
        bus.xk        = 1'b0;
        bus.zk        = 1'b0;
        bus.zkp       = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", all_outs(), 64'd0);
        rst = 1'b1;

        send_block(0, 4, 6'd0, 6'd0, 6'd0, 12'd0, 0, -1, -1);
        idle(2);
        send_block(0, 4, PX, PZ, PZP, 12'b101_010_111_000, 0, -1, -1);
        idle(2);
        send_block(0, 4, PX, FZ, PZP, 12'b101_010_111_000, 1, -1, -1);
        idle(2);
        send_block(1, 6, PX, PZ6, ZP6, 12'b001_100_011_110, 0, -1, -1);
        send_block(0, 4, PX, PZ, PZP, 12'b110_001_010_101, 0, -1, -1);
        idle(2);
        send_block(0, 4, PX, FZ, PZP, 12'b011_011_011_011, 1, -1, -1);
        idle(2);
        send_block(1, 6, PX, PZ6, ZP6, 12'd0, 1, 2, -1);
        idle(2);
        send_block(0, 4, PX, PZ, PZP, 12'b100_100_001_001, 0, -1, -1);
        idle(2);
        send_block(0, 4, PX, FZ, PZP, 12'b010_101_010_101, 1, -1, -1);
        idle(1);
        send_block(0, 4, PX, PZ, PZP, 12'b111_000_111_000, 0, -1, 1);
        drv(0, 0, 0, 0, 0);
        rst = 1'b1;
        idle(2);
        send_block(1, 6, PX, PZ6, ZP6, 12'b101_010_111_000, 0, -1, -1);
        idle(4);

        check("data_queue_drained", 64'(dq.size()), 64'd0);
        check("done_queue_drained", 64'(bq.size()), 64'd0);
        check("gap_queue_drained", 64'(gq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/turbo_deframer.md
# turbo_deframer

Receive-side companion to the turbo encoder's serial output port. Consumes the `look_now`-qualified `{xk, zk, zkp}` triplet stream and the per-block length flag, and splits each block into K data triplets and 4 trellis-tail triplets. Re-runs the constituent RSC encoder on the received systematic bits to check the first parity stream, then reports each block with start, end, tail and error indications. It sits at the encoder output in loopback benches and at the input of the downstream decoder datapath.

## Interface
- `K_SHORT`, default 4: data triplets per block when the length flag is 0.
- `K_LONG`, default 6: data triplets per block when the length flag is 1.
- `CNT_W`, default 14: width of the bit index counter.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `look_now`  in  1  input triplet valid.
- `length_in`  in  1  block length flag; sampled only on the first triplet of a block.
- `xk`, `zk`, `zkp`  in  1 each  systematic, parity-1 and parity-2 bits.
- `sys_bit`, `par1_bit`, `par2_bit`  out  1 each  registered data-triplet bits.
- `bit_valid`  out  1  data triplet present on the outputs.
- `bit_idx`  out  CNT_W  index of the current data triplet, 0..K-1.
- `sof`, `eof`  out  1  asserted with `bit_idx`=0 and with `bit_idx`=K-1 respectively.
- `tail_bits`  out  12  tail triplets, first triplet in [11:9], as {x,z,zp}.
- `block_done`  out  1  one-cycle pulse; `tail_bits` and `parity_err` are valid in this cycle.
- `parity_err`  out  1  zk mismatch seen in the finished block.
- `gap_err`  out  1  one-cycle pulse when a block is aborted.
- `state`  out  2  current FSM state, for debug.

## Operation
- States: IDLE=0, DATA=1, TAIL=2.
- **IDLE.** When `look_now`=1:
  - latch K from `length_in` (K_LONG if 1, else K_SHORT);
  - clear the RSC state s[2:0] and the error flag;
  - treat this triplet as data index 0 and go to DATA (or to TAIL if K=1).
- **DATA.** Each cycle with `look_now`=1 accepts one triplet and increments the index. After triplet K-1 is accepted, go to TAIL with the tail counter at 0.
- **TAIL.** Each cycle with `look_now`=1 shifts {xk,zk,zkp} into `tail_bits` from the LSB end. After the 4th tail triplet, pulse `block_done` and return to IDLE.
- **Back-to-back blocks.** `look_now` held high across the block boundary starts the next block on the very next cycle with no dead cycle. `length_in` is re-sampled at that point.
- **RSC check (data triplets only).** With s0=D, s1=D², s2=D³:
  - a = xk^s1^s2;
  - expected z = a^s0^s2;
  - update s2<=s1, s1<=s0, s0<=a;
  - if zk differs from expected z, set the block error flag.
  - `zkp` and the tail triplets are passed through and not checked.
- **Gap.** `look_now`=0 while in DATA or TAIL:
  - pulse `gap_err` and return to IDLE;
  - no `block_done`; the partial block is discarded;
  - `parity_err` is unchanged.
- `look_now`=0 in IDLE is idle, not an error.

## Timing
- One cycle of latency: the triplet sampled at edge n appears on `sys_bit`/`par1_bit`/`par2_bit`/`bit_valid`/`bit_idx`/`sof`/`eof` after edge n.
- `block_done`, the final `tail_bits` and `parity_err` are all valid in the cycle after the 4th tail triplet is sampled. This is the same cycle in which the next block's `sof` may appear.
- `parity_err` holds its value until the next `block_done`. It then includes any mismatch on data index K-1.
- `gap_err` is asserted in the cycle after the low `look_now` is sampled.
- Reset values (asynchronous, while `rst`=0):
  - state IDLE;
  - all outputs 0, `tail_bits`=0, counters 0, s=000.
- Reset asserted mid-block discards the block, with no `block_done` and no `gap_err`.
- `bit_idx` never exceeds K-1, and the tail counter never exceeds 3. Both counters wrap to 0 on block completion.

## Test plan
- **Short block, all zeros.** `length_in`=0, 8 triplets of 000:
  - `bit_idx` 0..3 with `sof` at 0 and `eof` at 3;
  - `block_done` one cycle after the 8th triplet;
  - `tail_bits`=0, `parity_err`=0.
- **Parity pass.** K=4, xk=1,0,1,1 with zk=1,1,0,1, then 4 tail triplets 101,010,111,000:
  - `parity_err`=0;
  - `tail_bits`=12'b101_010_111_000.
- **Parity fail.** Same stimulus with zk[2] flipped to 1: `parity_err`=1 at `block_done`.
- **Back-to-back blocks.** `look_now` held high for a K=6 block (10 triplets) followed by a K=4 block (8 triplets):
  - two `block_done` pulses 8 cycles apart;
  - the second `sof` is coincident with the first `block_done`.
- **Gap abort.** `look_now` dropped at data index 2:
  - `gap_err` pulses once, state returns to IDLE;
  - no `block_done`;
  - the next block decodes cleanly.
- **Reset mid-tail.** `rst` pulled low during tail triplet 1:
  - all outputs go to 0 immediately;
  - no `block_done`.
